// File: rtl/button_gesture.sv
// Gesture classifier: turns debounced press/release strobes into short, double, long and
// auto-repeat event pulses. Define GESTURE_REPEAT_EN to enable repeat_tick generation.
module button_gesture #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned DBL_CYCLES    = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    input  logic btn_ondn,
    input  logic btn_onup,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);

    localparam int unsigned MaxLd = (LONG_CYCLES > DBL_CYCLES) ? LONG_CYCLES : DBL_CYCLES;
    localparam int unsigned MaxP  = (MaxLd > REPEAT_CYCLES) ? MaxLd : REPEAT_CYCLES;
    localparam int unsigned CntW  = (MaxP > 2) ? $clog2(MaxP) : 1;

    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
    localparam logic [CntW-1:0] DblLast  = CntW'(DBL_CYCLES - 1);
`ifdef GESTURE_REPEAT_EN
    localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);
`endif

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPress1 = 3'd1;
    localparam logic [2:0] StWait2  = 3'd2;
    localparam logic [2:0] StPress2 = 3'd3;
    localparam logic [2:0] StLong   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            short_d, double_d, long_d, repeat_d, held_d;
    logic            cnt_restart;
    logic            dn, up;

    // The level is informational only; gestures start solely on a press strobe.
    logic unused_level;
    assign unused_level = btn_level;

    // Coincident press and release strobes cancel each other.
    assign dn = btn_ondn & ~btn_onup;
    assign up = btn_onup & ~btn_ondn;

    always_comb begin
        state_d     = state_q;
        cnt_restart = 1'b0;
        short_d     = 1'b0;
        double_d    = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (dn) state_d = StPress1;
            end
            StPress1: begin
                if (up) begin
                    state_d = StWait2;
                end else if (cnt_q == LongLast) begin
                    long_d  = 1'b1;
                    state_d = StLong;
                end
            end
            StWait2: begin
                if (dn) begin
                    double_d = 1'b1;
                    state_d  = StPress2;
                end else if (cnt_q == DblLast) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StPress2: begin
                if (up) state_d = StIdle;
            end
            StLong: begin
                if (up) begin
                    state_d = StIdle;
                end
`ifdef GESTURE_REPEAT_EN
                else if (cnt_q == RepLast) begin
                    repeat_d    = 1'b1;
                    cnt_restart = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || cnt_restart) begin
            cnt_d = '0;
`ifndef GESTURE_REPEAT_EN
        end else if (state_q == StLong) begin
            cnt_d = '0;
`endif
        end else if (cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign held_d = (state_d == StPress1) || (state_d == StPress2) || (state_d == StLong);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            held         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            short_press  <= short_d;
            double_press <= double_d;
            long_press   <= long_d;
            repeat_tick  <= repeat_d;
            held         <= held_d;
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: timestamp-based gesture model checked every cycle, directed
// scenarios with literal event times, then randomized strobes and occasional resets.
module tb_button_gesture;

    localparam int unsigned LongC = 8;
    localparam int unsigned DblC  = 6;
    localparam int unsigned RepC  = 4;
`ifdef GESTURE_REPEAT_EN
    localparam int RepEn = 1;
`else
    localparam int RepEn = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_level = 1'b0;
    logic btn_ondn = 1'b0;
    logic btn_onup = 1'b0;
    logic short_press, double_press, long_press, repeat_tick, held;

    button_gesture #(
        .LONG_CYCLES  (LongC),
        .DBL_CYCLES   (DblC),
        .REPEAT_CYCLES(RepC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_level   (btn_level),
        .btn_ondn    (btn_ondn),
        .btn_onup    (btn_onup),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .held        (held)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int t      = 0;
    int base   = 0;

    // Gesture model: phase plus timestamps of the press, release and long-press decision.
    typedef enum int {GIdle, GHold, GGap, GHoldAgain, GLongHold} phase_e;
    phase_e m_phase = GIdle;
    int m_t_press = 0, m_t_rel = 0, m_t_long = 0;
    logic e_short = 0, e_dbl = 0, e_long = 0, e_rep = 0, e_held = 0;

    int q_short[$], q_dbl[$], q_long[$], q_rep[$], q_held[$];

    task automatic chk(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, t, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int qfirst(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic int qlast(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    // Inputs seen in cycle now decide the outputs visible in cycle now+1.
    task automatic model_step(input logic dn_raw, input logic up_raw, input logic rs,
                              input int now);
        logic dn, up;
        dn = dn_raw && !up_raw;
        up = up_raw && !dn_raw;
        e_short = 0; e_dbl = 0; e_long = 0; e_rep = 0;
        if (rs) begin
            m_phase = GIdle;
        end else begin
            case (m_phase)
                GIdle: if (dn) begin m_phase = GHold; m_t_press = now; end
                GHold: begin
                    if (up) begin
                        m_phase = GGap; m_t_rel = now;
                    end else if (now - m_t_press == int'(LongC)) begin
                        e_long = 1; m_phase = GLongHold; m_t_long = now;
                    end
                end
                GGap: begin
                    if (dn) begin
                        e_dbl = 1; m_phase = GHoldAgain;
                    end else if (now - m_t_rel == int'(DblC)) begin
                        e_short = 1; m_phase = GIdle;
                    end
                end
                GHoldAgain: if (up) m_phase = GIdle;
                GLongHold: begin
                    if (up) m_phase = GIdle;
                    else if (RepEn != 0 && ((now - m_t_long) % int'(RepC)) == 0) e_rep = 1;
                end
                default: m_phase = GIdle;
            endcase
        end
        e_held = (m_phase == GHold) || (m_phase == GHoldAgain) || (m_phase == GLongHold);
    endtask

    // One cycle: check this cycle's outputs, apply this cycle's inputs, advance the model.
    task automatic tick(input logic dn, input logic up, input logic lvl, input logic rs);
        @(posedge clk);
        #1;
        chk("short_press", short_press, e_short);
        chk("double_press", double_press, e_dbl);
        chk("long_press", long_press, e_long);
        chk("repeat_tick", repeat_tick, e_rep);
        chk("held", held, e_held);
        if (short_press === 1'b1) q_short.push_back(t - base);
        if (double_press === 1'b1) q_dbl.push_back(t - base);
        if (long_press === 1'b1) q_long.push_back(t - base);
        if (repeat_tick === 1'b1) q_rep.push_back(t - base);
        if (held === 1'b1) q_held.push_back(t - base);
        btn_ondn  = dn;
        btn_onup  = up;
        btn_level = lvl;
        rst       = rs;
        if (rs) begin
            #1;
            chk("async_rst_events", short_press | double_press | long_press | repeat_tick, 1'b0);
            chk("async_rst_held", held, 1'b0);
        end
        model_step(dn, up, rs, t);
        t++;
    endtask

    // Directed scenario; -1 disables a stimulus slot.
    task automatic scen(input int d1, input int u1, input int d2, input int u2, input int rs_at,
                        input logic lvl_all, input int len);
        logic lvl;
        lvl = 1'b0;
        q_short.delete(); q_dbl.delete(); q_long.delete(); q_rep.delete(); q_held.delete();
        base = t;
        for (int r = 0; r < len; r++) begin
            logic dn, up;
            dn = (r == d1) || (r == d2);
            up = (r == u1) || (r == u2);
            if (dn) lvl = 1'b1;
            if (up) lvl = 1'b0;
            tick(dn, up, lvl | lvl_all, r == rs_at);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Short press
        scen(10, 13, -1, -1, -1, 1'b0, 30);
        chk_int("short.count", q_short.size(), 1);
        chk_int("short.at", qfirst(q_short), 20);
        chk_int("short.held_len", q_held.size(), 3);
        chk_int("short.held_first", qfirst(q_held), 11);
        chk_int("short.held_last", qlast(q_held), 13);
        chk_int("short.others", q_dbl.size() + q_long.size() + q_rep.size(), 0);

        // Double press with a long second hold
        scen(10, 13, 16, 30, -1, 1'b0, 45);
        chk_int("double.count", q_dbl.size(), 1);
        chk_int("double.at", qfirst(q_dbl), 17);
        chk_int("double.others", q_short.size() + q_long.size() + q_rep.size(), 0);

        // Long press, repeat depends on build
        scen(10, 35, -1, -1, -1, 1'b0, 45);
        chk_int("long.count", q_long.size(), 1);
        chk_int("long.at", qfirst(q_long), 19);
        chk_int("long.rep_count", q_rep.size(), 4 * RepEn);
        chk_int("long.rep_first", qfirst(q_rep), (RepEn != 0) ? 23 : -1);
        chk_int("long.rep_last", qlast(q_rep), (RepEn != 0) ? 35 : -1);
        chk_int("long.held_last", qlast(q_held), 35);

        // Release exactly on the long-press cycle
        scen(10, 18, -1, -1, -1, 1'b0, 35);
        chk_int("edge_rel.long", q_long.size(), 0);
        chk_int("edge_rel.short_at", qfirst(q_short), 25);

        // Second press exactly on window expiry
        scen(10, 13, 19, 22, -1, 1'b0, 35);
        chk_int("edge_dbl.at", qfirst(q_dbl), 20);
        chk_int("edge_dbl.short", q_short.size(), 0);

        // Reset mid-press, button physically held across it
        scen(10, 25, -1, -1, 15, 1'b0, 45);
        chk_int("rst.events", q_short.size() + q_dbl.size() + q_long.size() + q_rep.size(), 0);
        chk_int("rst.held_len", q_held.size(), 5);

        // Level high without any strobe
        scen(-1, -1, -1, -1, -1, 1'b1, 30);
        chk_int("level.activity", q_short.size() + q_dbl.size() + q_long.size()
                + q_rep.size() + q_held.size(), 0);

        // Coincident strobes in idle
        scen(10, 10, -1, -1, -1, 1'b0, 30);
        chk_int("both.activity", q_short.size() + q_dbl.size() + q_long.size()
                + q_rep.size() + q_held.size(), 0);

        // Randomized strobes, level noise and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic dn, up, lv, rs;
            dn = ($urandom_range(0, 7) == 0);
            up = ($urandom_range(0, 7) == 0);
            lv = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 299) == 0);
            tick(dn, up, lv, rs);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/button_gesture.md
# button_gesture

Classifies the debounced push-button stream into user gestures: short press, double press, long press and auto-repeat. Sits directly downstream of the per-button debouncer and consumes its debounced level and its one-tick press/release strobes. Emits single-cycle, registered event pulses to the game/UI control logic.

## Interface

Parameters:
- `LONG_CYCLES`, default 50_000_000: hold time that qualifies a long press (0.5 s at 100 MHz); minimum 2.
- `DBL_CYCLES`, default 25_000_000: window after a short release in which a second press counts as a double press; minimum 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period once a long press is held; minimum 2.

Ports:
- `clk` input, 1 bit: system clock, 100 MHz.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `btn_level` input, 1 bit: debounced button level (1 = pressed).
- `btn_ondn` input, 1 bit: one-cycle strobe on press.
- `btn_onup` input, 1 bit: one-cycle strobe on release.
- `short_press` output, 1 bit: one-cycle pulse, single short click confirmed.
- `double_press` output, 1 bit: one-cycle pulse, second press inside the double window.
- `long_press` output, 1 bit: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_tick` output, 1 bit: one-cycle pulse every `REPEAT_CYCLES` while a long press is held.
- `held` output, 1 bit: high while the FSM tracks a press (states PRESS1, PRESS2, LONG).

## Operation

- Single counter `cnt`.
  - Width is `$clog2` of the largest parameter.
  - Cleared on every state change; otherwise increments.
  - Saturates at its maximum and never wraps.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG.
- IDLE:
  - `btn_ondn` goes to PRESS1.
  - `btn_level` alone does not start a gesture. A button held through reset is ignored until a later press.
- PRESS1:
  - `btn_onup` goes to WAIT2.
  - If `cnt == LONG_CYCLES-1`, pulse `long_press` and go to LONG.
  - If both happen in the same cycle, the release wins: go to WAIT2, no `long_press`.
- WAIT2:
  - `btn_ondn` pulses `double_press` and goes to PRESS2.
  - If `cnt == DBL_CYCLES-1` with no press, pulse `short_press` and go to IDLE.
  - If both happen in the same cycle, the press wins: `double_press` only.
- PRESS2: `btn_onup` goes to IDLE. The hold duration is ignored and no further events are emitted.
- LONG:
  - Pulse `repeat_tick` each time `cnt == REPEAT_CYCLES-1`, then restart `cnt` at 0.
  - `btn_onup` goes to IDLE. A release on a tick cycle suppresses that tick.
- `btn_ondn` and `btn_onup` asserted in the same cycle: both are ignored.
- A strobe that is irrelevant in the current state is ignored (for example `btn_onup` in IDLE, or `btn_ondn` in PRESS1).
- At most one of the four event outputs is high in any cycle.

## Timing

- Reset values:
  - State IDLE, `cnt` = 0.
  - `short_press`, `double_press`, `long_press`, `repeat_tick` and `held` all 0.
- Reset asserted mid-gesture aborts it immediately and emits no events. After release, only a new `btn_ondn` starts a gesture.
- All outputs are registered. Each event pulse is high exactly 1 cycle, in the cycle after the qualifying condition.
- Latencies, with the press strobe at cycle N:
  - `held` rises at N+1.
  - `long_press` is high at cycle N+LONG_CYCLES+1, provided there is no release up to cycle N+LONG_CYCLES.
  - Repeat ticks then follow every `REPEAT_CYCLES` cycles.
- Short press: with the release strobe at cycle R, `short_press` is high at R+DBL_CYCLES+1 if no press arrives.
- Double press: with the second press strobe at cycle D, `double_press` is high at D+1.
- `held` falls 1 cycle after the terminating `btn_onup`.

## Configuration

- `GESTURE_REPEAT_EN` defined: the LONG state generates `repeat_tick` as specified.
- `GESTURE_REPEAT_EN` undefined:
  - The repeat logic is removed and `repeat_tick` is tied to 0.
  - The LONG state only waits for `btn_onup`; its counter stays at 0.
  - `REPEAT_CYCLES` is unused.

## Test plan

Bench uses `LONG_CYCLES`=8, `DBL_CYCLES`=6, `REPEAT_CYCLES`=4, with the press strobe at cycle 10.
- Short press:
  - Release at cycle 13, no further input.
  - Required: `short_press` high only at cycle 20; `held` high for cycles 11–13; no other events.
- Double press:
  - Release at 13, second press at 16, release at 30.
  - Required: `double_press` high only at 17; no `long_press` despite the long hold; no `short_press`.
- Long press with repeat (macro defined):
  - Hold until release at 35.
  - Required: `long_press` at 19; `repeat_tick` at 23, 27, 31 and 35; no tick at 36; `held` low from 36.
- Same hold with the macro undefined: `long_press` at 19; `repeat_tick` stays 0.
- Boundary cases:
  - Release exactly at cycle 18 gives no `long_press` and `short_press` at 25.
  - Press in WAIT2 exactly on the window-expiry cycle gives `double_press` and no `short_press`.
- Reset and ignored inputs:
  - `rst` pulsed at cycle 15 mid-press: all outputs 0, no events afterwards.
  - `btn_level`=1 with no press strobe after reset: no events.
  - Simultaneous press and release strobes in IDLE: no events.
